// File: rtl/pln_cpu_mc.sv
// -----------------------------------------------------------------------------
// pln_cpu_mc -- parametrised multicycle PLN CPU core
//
// Purpose:
//   Strictly sequential FETCH / DECODE / EXEC / MEM / WB core. It has an 8-entry
//   register file in which r0 always reads zero, and PC-relative branches and
//   jumps. Instruction and data memories use a variable-latency req/ready
//   handshake. The HALT instruction stops the core until reset.
//
// Parameters:
//   XLEN      data / register width (>= 16)
//   PC_W      instruction address width (>= 10 so imm9 fits)
//   DA_W      data address width (<= XLEN)
//   RESET_PC  pc value after reset
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   imem_req/addr        fetch request; addr is the pc, held until ready
//   imem_ready/rdata     fetch completes when req && ready; 16-bit instruction
//   dmem_req/we          data request; we=1 for store, held until ready
//   dmem_addr/wdata      data address and store data, stable while req
//   dmem_ready/rdata     transfer completes when req && ready; load data
//   retire               one-cycle pulse in the last cycle of each instruction
//   halted               core stopped by HALT
// -----------------------------------------------------------------------------
module pln_cpu_mc #(
    parameter int              XLEN     = 16,
    parameter int              PC_W     = 16,
    parameter int              DA_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DA_W-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted
);

    // Sequencer states
    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    // Opcodes (12..14 behave as NOP)
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_JAL  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_npc;   // pc of the next instruction, computed in EXEC
    logic [15:0]     r_ir;
    logic [XLEN-1:0] r_a;     // rs1 operand
    logic [XLEN-1:0] r_b;     // rs2 operand
    logic [XLEN-1:0] r_d;     // rd operand (branch compare / store data)
    logic [XLEN-1:0] r_alu;   // ALU result, then data address, then load data
    logic [XLEN-1:0] r_rf [8];

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]      w_op;
    logic [2:0]      w_rd;
    logic [2:0]      w_rs1;
    logic [2:0]      w_rs2;
    logic [XLEN-1:0] w_imm6_x;
    logic [PC_W-1:0] w_imm6_p;
    logic [PC_W-1:0] w_imm9_p;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:9];
    assign w_rs1    = r_ir[8:6];
    assign w_rs2    = r_ir[5:3];
    assign w_imm6_x = {{(XLEN-6){r_ir[5]}}, r_ir[5:0]};
    assign w_imm6_p = {{(PC_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_imm9_p = {{(PC_W-9){r_ir[8]}}, r_ir[8:0]};

    // ------------------------------------------------------------------
    // Next pc and link value
    // ------------------------------------------------------------------
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_npc;
    logic [XLEN-1:0] w_link;
    logic            w_taken;

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_taken  = ((w_op == OP_BEQ) && (r_d == r_a)) ||
                      ((w_op == OP_BNE) && (r_d != r_a));
    assign w_npc    = (w_op == OP_JAL) ? (r_pc + w_imm9_p) :
                      w_taken          ? (r_pc + w_imm6_p) : w_pc_inc;

    // The JAL link is pc+1 zero-extended or truncated to the register width
    generate
        if (XLEN > PC_W) begin : g_link_ext
            assign w_link = {{(XLEN-PC_W){1'b0}}, w_pc_inc};
        end else if (XLEN == PC_W) begin : g_link_eq
            assign w_link = w_pc_inc;
        end else begin : g_link_trunc
            assign w_link = w_pc_inc[XLEN-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // ALU and instruction class
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_alu;
    logic            w_to_wb;
    logic            w_to_mem;
    logic            w_is_halt;
    logic            w_exec_retires;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    //       path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:                w_alu = r_a + r_b;
            OP_SUB:                w_alu = r_a - r_b;
            OP_AND:                w_alu = r_a & r_b;
            OP_OR:                 w_alu = r_a | r_b;
            OP_XOR:                w_alu = r_a ^ r_b;
            OP_ADDI, OP_LW, OP_SW: w_alu = r_a + w_imm6_x;
            OP_JAL:                w_alu = w_link;
            default:               w_alu = '0;
        endcase
    end

    assign w_to_wb        = ((w_op >= OP_ADD) && (w_op <= OP_ADDI)) || (w_op == OP_JAL);
    assign w_to_mem       = (w_op == OP_LW) || (w_op == OP_SW);
    assign w_is_halt      = (w_op == OP_HALT);
    // Branches, NOP and the unused opcodes complete in EXEC
    assign w_exec_retires = !(w_to_wb || w_to_mem || w_is_halt);

    // ------------------------------------------------------------------
    // Sequencer, register file and datapath registers
    // ------------------------------------------------------------------
    // NOTE: the register file is small and must read zero after reset, so it
    //       sits in the async-reset block along with the rest of the state.
    //       A large RAM would not be reset this way.
    // NOTE: all state is updated with non-blocking assignments. Every register
    //       then samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_pc    <= RESET_PC;
            r_npc   <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_alu   <= '0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_INIT: begin
                    r_state <= S_FETCH;
                end

                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    // r_rf[0] is never written, so r0 reads as zero
                    r_a     <= r_rf[w_rs1];
                    r_b     <= r_rf[w_rs2];
                    r_d     <= r_rf[w_rd];
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    r_alu <= w_alu;
                    r_npc <= w_npc;
                    if (w_to_mem) begin
                        r_state <= S_MEM;
                    end else if (w_to_wb) begin
                        r_state <= S_WB;
                    end else if (w_is_halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_pc    <= w_npc;
                        r_state <= S_FETCH;
                    end
                end

                S_MEM: begin
                    // r_alu holds the address and stays put until the transfer completes
                    if (dmem_ready) begin
                        if (w_op == OP_SW) begin
                            r_pc    <= r_npc;
                            r_state <= S_FETCH;
                        end else begin
                            r_alu   <= dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    if (w_rd != 3'd0) begin
                        r_rf[w_rd] <= r_alu;
                    end
                    r_pc    <= r_npc;
                    r_state <= S_FETCH;
                end

                S_HALTED: begin
                    r_state <= S_HALTED;
                end

                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the registered state. The async reset forces
    // the state back to INIT, so requests drop as soon as rst rises.
    // ------------------------------------------------------------------
    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = imem_req ? r_pc : '0;

    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = dmem_req && (w_op == OP_SW);
    assign dmem_addr  = dmem_req ? r_alu[DA_W-1:0] : '0;
    assign dmem_wdata = dmem_req ? r_d : '0;

    assign retire     = ((r_state == S_EXEC) && w_exec_retires) ||
                        ((r_state == S_MEM) && dmem_ready && (w_op == OP_SW)) ||
                        (r_state == S_WB);
    assign halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_pln_cpu_mc.sv
// -----------------------------------------------------------------------------
// tb_pln_cpu_mc -- directed bench for pln_cpu_mc
//
// Two cores run side by side:
//   u_dut_a : XLEN=16, RESET_PC=0. Runs the ALU, load/store, branch, jump and
//             halt programs. Its memories add wait states at chosen addresses.
//   u_dut_b : XLEN=32, RESET_PC=16, memories always ready. Runs the wrap-around
//             and r0 programs.
// Register contents are observed via stores. The pc is observed via fetch
// addresses.
// -----------------------------------------------------------------------------
module tb_pln_cpu_mc;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (16-bit) ----------------
    logic        imem_req_a, imem_ready_a, dmem_req_a, dmem_we_a, dmem_ready_a;
    logic        retire_a, halted_a;
    logic [15:0] imem_addr_a, imem_rdata_a, dmem_addr_a, dmem_wdata_a, dmem_rdata_a;
    logic [15:0] imem_a [256];
    logic [15:0] dmem_a [256];
    int          i_cnt_a = 0;
    int          d_cnt_a = 0;
    int          i_wait_a, d_wait_a;
    int          n_wr_a = 0;
    logic        d_block = 1'b0;

    pln_cpu_mc #(.XLEN(16), .PC_W(16), .DA_W(16), .RESET_PC(16'd0)) u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .imem_req   (imem_req_a),
        .imem_addr  (imem_addr_a),
        .imem_ready (imem_ready_a),
        .imem_rdata (imem_rdata_a),
        .dmem_req   (dmem_req_a),
        .dmem_we    (dmem_we_a),
        .dmem_addr  (dmem_addr_a),
        .dmem_wdata (dmem_wdata_a),
        .dmem_ready (dmem_ready_a),
        .dmem_rdata (dmem_rdata_a),
        .retire     (retire_a),
        .halted     (halted_a)
    );

    // Memory models: fetch of pc 20 waits 2 cycles, data address 4 waits 3 cycles
    assign i_wait_a     = (imem_addr_a == 16'd20) ? 2 : 0;
    assign d_wait_a     = (dmem_addr_a == 16'd4) ? 3 : 0;
    assign imem_ready_a = imem_req_a && (i_cnt_a >= i_wait_a);
    assign dmem_ready_a = dmem_req_a && !d_block && (d_cnt_a >= d_wait_a);
    assign imem_rdata_a = imem_a[imem_addr_a[7:0]];
    assign dmem_rdata_a = dmem_a[dmem_addr_a[7:0]];

    always @(posedge clk) begin
        i_cnt_a <= (imem_req_a && !imem_ready_a) ? i_cnt_a + 1 : 0;
        d_cnt_a <= (dmem_req_a && !dmem_ready_a) ? d_cnt_a + 1 : 0;
        if (dmem_req_a && dmem_ready_a && dmem_we_a) begin
            dmem_a[dmem_addr_a[7:0]] <= dmem_wdata_a;
            n_wr_a <= n_wr_a + 1;
        end
    end

    // ---------------- DUT B (32-bit) ----------------
    logic        imem_req_b, imem_ready_b, dmem_req_b, dmem_we_b, dmem_ready_b;
    logic        retire_b, halted_b;
    logic [15:0] imem_addr_b, imem_rdata_b, dmem_addr_b;
    logic [31:0] dmem_wdata_b, dmem_rdata_b;
    logic [15:0] imem_b [256];

    pln_cpu_mc #(.XLEN(32), .PC_W(16), .DA_W(16), .RESET_PC(16'd16)) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .imem_req   (imem_req_b),
        .imem_addr  (imem_addr_b),
        .imem_ready (imem_ready_b),
        .imem_rdata (imem_rdata_b),
        .dmem_req   (dmem_req_b),
        .dmem_we    (dmem_we_b),
        .dmem_addr  (dmem_addr_b),
        .dmem_wdata (dmem_wdata_b),
        .dmem_ready (dmem_ready_b),
        .dmem_rdata (dmem_rdata_b),
        .retire     (retire_b),
        .halted     (halted_b)
    );

    assign imem_ready_b = 1'b1;
    assign dmem_ready_b = 1'b1;
    assign dmem_rdata_b = '0;
    assign imem_rdata_b = imem_b[imem_addr_b[7:0]];

    // ---------------- Monitors (sampled on the falling edge) ----------------
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wd;
        int          len;
        logic        stable;
    } txn_t;

    int          ret_q[$];
    logic [15:0] fa_q[$];
    int          fc_q[$];
    txn_t        txn_q[$];
    logic [15:0] fb_q[$];
    logic [15:0] sb_addr[$];
    logic [31:0] sb_data[$];

    logic        in_txn = 1'b0;
    logic [15:0] t_addr = '0;
    logic        t_we = 1'b0;
    logic [15:0] t_wd = '0;
    int          t_len = 0;
    logic        t_stable = 1'b1;
    logic        t_chg;

    assign t_chg = in_txn && ((dmem_addr_a !== t_addr) || (dmem_we_a !== t_we) ||
                              (dmem_wdata_a !== t_wd));

    always @(negedge clk) begin
        if (retire_a) ret_q.push_back(cyc);
        if (imem_req_a && imem_ready_a) begin
            fa_q.push_back(imem_addr_a);
            fc_q.push_back(cyc);
        end
        if (dmem_req_a) begin
            if (!in_txn) begin
                t_addr   <= dmem_addr_a;
                t_we     <= dmem_we_a;
                t_wd     <= dmem_wdata_a;
                t_len    <= 1;
                t_stable <= 1'b1;
                in_txn   <= 1'b1;
            end else begin
                t_len <= t_len + 1;
                if (t_chg) t_stable <= 1'b0;
            end
            if (dmem_ready_a) begin
                txn_q.push_back(txn_t'{addr: dmem_addr_a, we: dmem_we_a, wd: dmem_wdata_a,
                                       len: in_txn ? t_len + 1 : 1,
                                       stable: in_txn ? (t_stable && !t_chg) : 1'b1});
                in_txn <= 1'b0;
            end
        end else begin
            in_txn <= 1'b0;
        end
        if (imem_req_b) fb_q.push_back(imem_addr_b);
        if (dmem_req_b && dmem_we_b) begin
            sb_addr.push_back(dmem_addr_b);
            sb_data.push_back(dmem_wdata_b);
        end
    end

    // ---------------- Checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Expected tables for program A
    int          ex_gap [16]   = '{4, 4, 4, 7, 8, 4, 4, 3, 3, 4, 6, 4, 4, 4, 3, 3};
    logic [15:0] ex_fa  [18]   = '{0, 1, 2, 3, 4, 5, 6, 7, 10, 8, 9, 20, 24, 25, 26, 27, 28, 29};
    logic [15:0] ex_taddr [6]  = '{8, 4, 4, 5, 6, 7};
    logic        ex_twe   [6]  = '{1, 1, 0, 1, 1, 1};
    logic [15:0] ex_twd   [6]  = '{2, 5, 0, 5, 21, 0};
    int          ex_tlen  [6]  = '{1, 4, 4, 1, 1, 1};
    logic [15:0] ex_sb_addr [3] = '{1, 2, 3};
    logic [31:0] ex_sb_data [3] = '{32'hFFFF_FFFF, 32'h0, 32'h0};

    int hc, fb2, tb2, w0, reqs;

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem_a[i] = 16'h0000;
            imem_b[i] = 16'h0000;
        end
        // Program A
        imem_a[0]  = 16'h6205; // ADDI r1,r0,5
        imem_a[1]  = 16'h643D; // ADDI r2,r0,-3
        imem_a[2]  = 16'h1650; // ADD  r3,r1,r2   -> 2
        imem_a[3]  = 16'h8608; // SW   r3,[r0+8]
        imem_a[4]  = 16'h8204; // SW   r1,[r0+4]  (3 wait cycles)
        imem_a[5]  = 16'h7804; // LW   r4,[r0+4]  (3 wait cycles)
        imem_a[6]  = 16'h8805; // SW   r4,[r0+5]
        imem_a[7]  = 16'hB003; // JAL  r0,+3      -> 10
        imem_a[10] = 16'h927E; // BEQ  r1,r1,-2   -> 8
        imem_a[8]  = 16'hA27E; // BNE  r1,r1,-2   -> 9
        imem_a[9]  = 16'hB00B; // JAL  r0,+11     -> 20
        imem_a[20] = 16'hBE04; // JAL  r7,+4      -> 24, r7=21
        imem_a[24] = 16'h8E06; // SW   r7,[r0+6]
        imem_a[25] = 16'h1048; // ADD  r0,r1,r1
        imem_a[26] = 16'h8007; // SW   r0,[r0+7]
        imem_a[27] = 16'hC000; // opcode 12 (NOP)
        imem_a[28] = 16'h0000; // NOP
        imem_a[29] = 16'hF000; // HALT
        // Program B (RESET_PC = 16)
        imem_b[16] = 16'h623F; // ADDI r1,r0,-1
        imem_b[17] = 16'h8201; // SW   r1,[r0+1]
        imem_b[18] = 16'h6241; // ADDI r1,r1,1    -> 0
        imem_b[19] = 16'h8202; // SW   r1,[r0+2]
        imem_b[20] = 16'h643F; // ADDI r2,r0,-1
        imem_b[21] = 16'h1090; // ADD  r0,r2,r2
        imem_b[22] = 16'h8003; // SW   r0,[r0+3]
        imem_b[23] = 16'hF000; // HALT

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {11'd0, imem_req_a, imem_addr_a, dmem_req_a, dmem_we_a,
                           dmem_addr_a, dmem_wdata_a, retire_a, halted_a}, 64'd0);
        chk("rst_outs_b_ctl", {imem_req_b, imem_addr_b, dmem_req_b, dmem_we_b,
                               dmem_addr_b, retire_b, halted_b}, 64'd0);
        chk("rst_outs_b_wdata", {32'd0, dmem_wdata_b}, 64'd0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("init_no_fetch_a", {63'd0, imem_req_a}, 64'd0);

        // ---- phase 1: run program A to HALT ----
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (halted_a) break;
        end
        hc = cyc;
        chk("halt_reached_a", {63'd0, halted_a}, 64'd1);
        chk("halt_reached_b", {63'd0, halted_b}, 64'd1);

        chk("retire_count", 64'(ret_q.size()), 64'd17);
        chk("fetch_count", 64'(fa_q.size()), 64'd18);
        if (ret_q.size() == 17 && fa_q.size() == 18) begin
            chk("first_latency", 64'(ret_q[0] - fc_q[0] + 1), 64'd4);
            for (int i = 1; i < 17; i++)
                chk($sformatf("retire_gap[%0d]", i), 64'(ret_q[i] - ret_q[i-1]), 64'(ex_gap[i-1]));
            for (int i = 0; i < 18; i++)
                chk($sformatf("fetch_pc[%0d]", i), {48'd0, fa_q[i]}, {48'd0, ex_fa[i]});
            chk("halt_delay", 64'(hc - fc_q[17]), 64'd3);
        end

        chk("txn_count", 64'(txn_q.size()), 64'd6);
        if (txn_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("txn_addr[%0d]", i), {48'd0, txn_q[i].addr}, {48'd0, ex_taddr[i]});
                chk($sformatf("txn_we[%0d]", i), {63'd0, txn_q[i].we}, {63'd0, ex_twe[i]});
                chk($sformatf("txn_wdata[%0d]", i), {48'd0, txn_q[i].wd}, {48'd0, ex_twd[i]});
                chk($sformatf("txn_len[%0d]", i), 64'(txn_q[i].len), 64'(ex_tlen[i]));
                chk($sformatf("txn_stable[%0d]", i), {63'd0, txn_q[i].stable}, 64'd1);
            end
        end

        chk("b_first_fetch", (fb_q.size() > 0) ? {48'd0, fb_q[0]} : 64'hDEAD, 64'd16);
        chk("b_store_count", 64'(sb_addr.size()), 64'd3);
        if (sb_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b_store_addr[%0d]", i), {48'd0, sb_addr[i]}, {48'd0, ex_sb_addr[i]});
                chk($sformatf("b_store_data[%0d]", i), {32'd0, sb_data[i]}, {32'd0, ex_sb_data[i]});
            end
        end

        // ---- phase 2: reset during MEM, then HALT at pc 6 ----
        @(negedge clk);
        rst_a   = 1'b1;
        d_block = 1'b1;
        for (int i = 0; i < 256; i++) imem_a[i] = 16'h0000;
        imem_a[0] = 16'h6205; // ADDI r1,r0,5
        imem_a[1] = 16'h8203; // SW   r1,[r0+3]
        imem_a[6] = 16'hF000; // HALT
        repeat (2) @(negedge clk);
        rst_a = 1'b0;

        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (dmem_req_a) break;
        end
        chk("mem_reached", {63'd0, dmem_req_a}, 64'd1);
        repeat (2) @(negedge clk);
        chk("mem_held_req", {63'd0, dmem_req_a}, 64'd1);
        chk("mem_held_addr", {48'd0, dmem_addr_a}, 64'd3);
        chk("mem_held_wdata", {48'd0, dmem_wdata_a}, 64'd5);
        w0 = n_wr_a;
        tb2 = txn_q.size();
        #2;
        rst_a = 1'b1;
        #1;
        chk("rst_drops_dmem", {dmem_req_a, dmem_we_a, dmem_addr_a, dmem_wdata_a}, 64'd0);
        chk("rst_drops_imem", {63'd0, imem_req_a}, 64'd0);
        d_block = 1'b0;
        @(negedge clk);
        chk("rst_no_write", 64'(n_wr_a - w0), 64'd0);
        rst_a = 1'b0;
        fb2 = fa_q.size();
        #1;
        chk("rst_init_no_fetch", {63'd0, imem_req_a}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_fetch_pc", {47'd0, imem_req_a, imem_addr_a}, {47'd0, 1'b1, 16'd0});

        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (halted_a) break;
        end
        hc = cyc;
        chk("halt2_reached", {63'd0, halted_a}, 64'd1);
        chk("fetch2_count", 64'(fa_q.size() - fb2), 64'd7);
        if (fa_q.size() - fb2 == 7) begin
            for (int i = 0; i < 7; i++)
                chk($sformatf("fetch2_pc[%0d]", i), {48'd0, fa_q[fb2+i]}, 64'(i));
            chk("halt2_delay", 64'(hc - fc_q[fb2+6]), 64'd3);
        end
        chk("store2_count", 64'(txn_q.size() - tb2), 64'd1);
        chk("store2_written", 64'(n_wr_a - w0), 64'd1);
        if (txn_q.size() == tb2 + 1)
            chk("store2_addr_data", {31'd0, txn_q[tb2].we, txn_q[tb2].addr, txn_q[tb2].wd},
                {31'd0, 1'b1, 16'd3, 16'd5});

        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req_a || dmem_req_a || retire_a) reqs++;
        end
        chk("halted_quiet", 64'(reqs), 64'd0);
        chk("halted_stays", {63'd0, halted_a}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
